// File: rtl/mux2_arbiter.sv
// Two-source fair arbiter driving a 2:1 word mux into a ready/valid sink.
// Sources alternate after MAX_BURST consecutive transfers while both are requesting.
module mux2_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic [DW-1:0] data_a,
    input  logic          req_b,
    input  logic [DW-1:0] data_b,
    input  logic          out_ready,
    output logic          ack_a,
    output logic          ack_b,
    output logic          sel,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic       SRC_A   = 1'b0;
    localparam logic       SRC_B   = 1'b1;
    localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic       sel_r;
    logic       sel_nxt_s;

    // Next-state, burst counter, last-granted and select computation.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        sel_nxt_s   = sel_r;
        case (state_r)
            IDLE: begin
                // A tie goes to whichever source was not granted most recently.
                if (req_a && (!req_b || (last_r == SRC_B))) begin
                    state_nxt_s = GNT_A;
                    last_nxt_s  = SRC_A;
                    sel_nxt_s   = 1'b0;
                    cnt_nxt_s   = 4'd0;
                end else if (req_b) begin
                    state_nxt_s = GNT_B;
                    last_nxt_s  = SRC_B;
                    sel_nxt_s   = 1'b1;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    cnt_nxt_s = 4'd0;
                    if (req_b) begin
                        state_nxt_s = GNT_B;
                        last_nxt_s  = SRC_B;
                        sel_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (out_ready) begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end else if (req_b) begin
                        state_nxt_s = GNT_B;
                        last_nxt_s  = SRC_B;
                        sel_nxt_s   = 1'b1;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s = CNT_MAX;
                    end
                end else begin
                    state_nxt_s = GNT_A;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    cnt_nxt_s = 4'd0;
                    if (req_a) begin
                        state_nxt_s = GNT_A;
                        last_nxt_s  = SRC_A;
                        sel_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (out_ready) begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end else if (req_a) begin
                        state_nxt_s = GNT_A;
                        last_nxt_s  = SRC_A;
                        sel_nxt_s   = 1'b0;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s = CNT_MAX;
                    end
                end else begin
                    state_nxt_s = GNT_B;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, counter, last-granted and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            last_r  <= SRC_B;
            sel_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    // Handshake is combinational on the registered grant so reset clears it at once.
    assign out_valid = ((state_r == GNT_A) && req_a) || ((state_r == GNT_B) && req_b);
    assign ack_a     = (state_r == GNT_A) && req_a && out_ready;
    assign ack_b     = (state_r == GNT_B) && req_b && out_ready;
    assign sel       = sel_r;
    assign out_data  = sel_r ? data_b : data_a;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter (DW=8, MAX_BURST=4).
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a;
    logic [7:0] data_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       out_ready;
    logic       ack_a;
    logic       ack_b;
    logic       sel;
    logic       out_valid;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    mux2_arbiter #(.DW(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .out_ready (out_ready),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
        data_a = 8'h11; data_b = 8'h22; out_ready = 1'b1;

        // Reset with both sources requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_ack_a", 32'(ack_a), 32'd1);
        chk("rel_sel", 32'(sel), 32'd0);
        chk("rel_data", 32'(out_data), 32'h11);
        req_a = 1'b0; req_b = 1'b0;
        #1;
        chk("rel_drop_valid", 32'(out_valid), 32'd0);
        tick();

        // Single source B
        req_b = 1'b1; data_b = 8'h5A;
        #1;
        chk("b_idle_valid", 32'(out_valid), 32'd0);
        tick();
        chk("b_sel", 32'(sel), 32'd1);
        chk("b_ack_b", 32'(ack_b), 32'd1);
        chk("b_ack_a", 32'(ack_a), 32'd0);
        chk("b_data", 32'(out_data), 32'h5A);
        req_b = 1'b0;
        tick();
        chk("b_idle_sel_hold", 32'(sel), 32'd1);

        // Fairness: both requesting, A wins the tie since last=B
        req_a = 1'b1; req_b = 1'b1; data_a = 8'hA0; data_b = 8'hB0;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("fair_ack_a_%0d", i), 32'(ack_a), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("fair_ack_b_%0d", i), 32'(ack_b), ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("fair_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("fair_data_%0d", i), 32'(out_data), ((i / 4) % 2 == 1) ? 32'hB0 : 32'hA0);
            tick();
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();

        // Backpressure in GNT_A
        req_a = 1'b1; data_a = 8'h3C;
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_data_%0d", i), 32'(out_data), 32'h3C);
            chk($sformatf("bp_ack_a_%0d", i), 32'(ack_a), 32'd0);
            chk($sformatf("bp_cnt_%0d", i), 32'(dut.cnt_r), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ack_release", 32'(ack_a), 32'd1);
        tick();
        chk("bp_cnt_after", 32'(dut.cnt_r), 32'd1);
        req_a = 1'b0;
        #1;
        chk("bp_single_ack", 32'(ack_a), 32'd0);
        tick();

        // Early release: A sends 2 words then drops while B requests
        req_a = 1'b1;
        tick();
        req_b = 1'b1;
        #1;
        chk("er_a_w1", 32'(ack_a), 32'd1);
        tick();
        chk("er_a_w2", 32'(ack_a), 32'd1);
        tick();
        req_a = 1'b0;
        #1;
        chk("er_gap_valid", 32'(out_valid), 32'd0);
        tick();
        chk("er_cnt", 32'(dut.cnt_r), 32'd0);
        chk("er_sel", 32'(sel), 32'd1);
        req_a = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("er_b_burst_%0d", i), 32'(ack_b), 32'd1);
            tick();
        end
        chk("er_back_a", 32'(ack_a), 32'd1);
        chk("er_back_b", 32'(ack_b), 32'd0);

        // Mid-burst reset during GNT_B
        req_a = 1'b0;
        tick();
        chk("mr_b_w1", 32'(ack_b), 32'd1);
        tick();
        chk("mr_b_w2", 32'(ack_b), 32'd1);
        tick();
        chk("mr_b_w3_pending", 32'(ack_b), 32'd1);
        req_a = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_ack_a", 32'(ack_a), 32'd0);
        chk("mr_ack_b", 32'(ack_b), 32'd0);
        chk("mr_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mr_tie_ack_a", 32'(ack_a), 32'd1);
        chk("mr_tie_sel", 32'(sel), 32'd0);
        chk("mr_tie_data", 32'(out_data), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter DW, default 8: data width of each source and of the output.
REQ-002 Parameter MAX_BURST, default 4, legal range 1..15: maximum consecutive transfers granted to one source while the other source is requesting.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_a  input  1  source A has a word on data_a.
REQ-006 data_a  input  DW  source A word.
REQ-007 req_b  input  1  source B has a word on data_b.
REQ-008 data_b  input  DW  source B word.
REQ-009 out_ready  input  1  sink accepts out_data this cycle.
REQ-010 ack_a  output  1  source A word consumed this cycle.
REQ-011 ack_b  output  1  source B word consumed this cycle.
REQ-012 sel  output  1  2:1 select: 0 = A, 1 = B.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_data  output  DW  selected word.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GNT_A and GNT_B, held in a registered state variable.
REQ-016 Source handshake: req_x SHALL stay high and data_x SHALL stay stable until ack_x; req_x SHALL then either fall or present the next word.
REQ-017 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL equal (GNT_A & req_a) | (GNT_B & req_b), combinationally.
REQ-019 ack_a SHALL equal GNT_A & req_a & out_ready.
REQ-020 ack_b SHALL equal GNT_B & req_b & out_ready.
REQ-021 ack_a and ack_b SHALL never be high together.
REQ-022 sel SHALL be registered: 1 in GNT_B, 0 in GNT_A, and holding its previous value in IDLE.
REQ-023 out_data SHALL equal data_b when sel=1 and data_a otherwise, combinationally.
REQ-024 A 1-bit last register SHALL record the most recently granted source.
REQ-025 A 4-bit burst counter cnt SHALL count transfers in the current grant.
REQ-026 IDLE, both requests high: go to the source that is not last.
REQ-027 IDLE, one request high: go to that source.
REQ-028 IDLE, no request: stay in IDLE.
REQ-029 Grant latency from IDLE SHALL be one cycle: req sampled at edge N gives out_valid in cycle N+1.
REQ-030 GNT_X with req_X low: go to GNT_other if the other source requests, else to IDLE; cnt SHALL clear.
REQ-031 GNT_X with a transfer: cnt SHALL increment.
REQ-032 If that transfer is transfer number MAX_BURST (cnt = MAX_BURST-1) and the other source requests, the FSM SHALL go to GNT_other and clear cnt.
REQ-033 If the other source is idle, cnt SHALL saturate at MAX_BURST-1 and the grant SHALL remain.
REQ-034 GNT_X with req_X high and no transfer (out_ready=0): hold state, cnt, sel and data.
REQ-035 Every entry into GNT_X SHALL set last=X and clear cnt.
REQ-036 On a switch, the new source's first word SHALL appear the cycle after the edge that switches.
REQ-037 No word SHALL be lost or duplicated across a switch.

Reset
REQ-038 While rst_n=0: state=IDLE, sel=0, cnt=0, last=B (so A wins the first tie), and out_valid, ack_a and ack_b SHALL be 0.
REQ-039 Reset asserted mid-grant SHALL abort immediately; any unacknowledged word SHALL remain owned by its source.
REQ-040 After rst_n rises, the first grant SHALL follow REQ-026 to REQ-028 from IDLE.

Verification
REQ-041 Reset check: rst_n=0 with req_a=req_b=1 -> out_valid=0, ack_a=ack_b=0, sel=0; release -> GNT_A next cycle, out_data=data_a.
REQ-042 Single source B: req_b=1, data_b=0x5A, out_ready=1 -> sel=1 one cycle later, ack_b=1, out_data=0x5A, ack_a stays 0.
REQ-043 Fairness with MAX_BURST=4, both requesting continuously, out_ready=1 -> ack pattern A,A,A,A,B,B,B,B,A...; zero idle cycles between bursts.
REQ-044 Backpressure: in GNT_A, out_ready=0 for 3 cycles -> out_valid=1 and data held, ack_a=0, cnt unchanged; on out_ready=1 a single ack_a.
REQ-045 Early release: A requests 2 words then drops req while B requests -> GNT_B follows, cnt=0, B receives a full 4-word burst.
REQ-046 Mid-burst reset: rst_n pulsed low after 2 transfers to B -> outputs zero asynchronously; after release, tie goes to A.
